gpio_pad_if: RTL and testbench
==============================

# gpio_pad_if

Per-pin conditioning stage between the GPIO register block inside `rv32i_soc` and the 32 bidirectional `PDD24DGZ` pad cells.
- Input path: synchronises the asynchronous pad `C` outputs, optionally debounces them, and detects rising/falling edges into sticky interrupt-pending bits.
- Output path: registers the output data and direction toward the pad `I`/`OEN` pins so that no combinational glitch reaches the pads.

## Interface
Parameters:
- `NUM_PINS`, 32: number of GPIO pins.
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `DB_CNT_W`, 16: width of the debounce tick prescaler.

Ports:
- `clk`  in  1  system clock, the SoC core clock. Single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `i_pad_c`  in  NUM_PINS  raw pad `C` outputs; asynchronous to `clk`.
- `o_pad_i`  out  NUM_PINS  drive value to pad `I`.
- `o_pad_oen`  out  NUM_PINS  pad output enable, active-low (1 = input).
- `i_gpio_out`  in  NUM_PINS  output data from GPIO registers.
- `i_gpio_dir`  in  NUM_PINS  direction from GPIO registers (1 = output).
- `o_gpio_in`  out  NUM_PINS  conditioned input value.
- `i_rise_en`  in  NUM_PINS  rising-edge interrupt enable.
- `i_fall_en`  in  NUM_PINS  falling-edge interrupt enable.
- `i_irq_clr`  in  NUM_PINS  one-cycle clear pulses (write-1-to-clear).
- `o_irq_pending`  out  NUM_PINS  sticky pending bits.
- `o_irq`  out  1  OR of all pending bits.
- `i_db_limit`  in  DB_CNT_W  debounce sample period minus 1.

## Operation
- **Reset values:**
  - `o_pad_oen` = all 1s, so every pin is an input.
  - `o_pad_i`, `o_gpio_in`, `o_irq_pending` = 0; `o_irq` = 0.
  - All internal sync, history, previous-value and counter registers = 0.
- **Output path:**
  - `o_pad_i` is registered from `i_gpio_out`.
  - `o_pad_oen` is registered from `~i_gpio_dir`.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain per pin on `i_pad_c`; its output is `s`.
- **Debounce (only with the macro):**
  - Shared prescaler counter: increments each cycle. When `count >= i_db_limit`, it emits `tick` and returns to 0, so the tick period is `i_db_limit+1` cycles. `i_db_limit` = 0 gives a tick every cycle.
  - Lowering `i_db_limit` below the current count produces a tick on the next cycle.
  - Per pin, on `tick`:
    - shift `s` into the 2-bit history `h`;
    - if `s == h[0] == h[1]` (compared before the update), `cond <= s`.
  - A value is therefore accepted after 3 consecutive equal samples. Glitches shorter than 2 tick periods never reach `cond`.
- **Conditioned value:** `o_gpio_in = cond`. The pin is read back from the pad even when it is configured as an output.
- **Edge detection:**
  - `prev <= cond` every cycle.
  - `rise = cond & ~prev & i_rise_en`; `fall = ~cond & prev & i_fall_en`.
- **Pending bits:** `pending <= (pending & ~i_irq_clr) | rise | fall`. When set and clear occur in the same cycle, set wins.
- **Interrupt:** `o_irq = |pending`, combinational from registered bits.
- **Edges during reset:** enables are expected to be 0 out of reset, so pins that are high at reset raise no pending bit. Enabling an edge type does not retroactively flag past edges.

## Timing
- Output path latency: 1 cycle from `i_gpio_out`/`i_gpio_dir` to the pad pins.
- Pad change to `o_gpio_in`:
  - without debounce: `SYNC_STAGES` edges;
  - with debounce and `i_db_limit` = 0: `SYNC_STAGES+3` edges;
  - with debounce in general: at most `SYNC_STAGES + 3*(i_db_limit+1)` edges.
- `o_gpio_in` change to `o_irq_pending`/`o_irq`: 1 cycle.
- `i_irq_clr` to pending cleared: 1 cycle.
- Asynchronous `reset` asserted mid-debounce: all state, including counter and history, clears immediately. Post-reset acceptance restarts from zero history.

## Configuration
- Macro: `GPIO_DEBOUNCE_EN`.
- Defined: prescaler and history registers are present; `cond` updates per the debounce rule.
- Undefined: no prescaler or history logic is generated; `cond = s` directly; `i_db_limit` is ignored (left unconnected internally). Edge logic is unchanged.

## Structure
- Shared package `gpio_pkg`: `GPIO_NUM_PINS`, `GPIO_SYNC_STAGES`, `GPIO_DB_CNT_W` constants, and a `gpio_edge_t` enum (`EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`).
- One sub-module, `gpio_debounce`: the shared prescaler plus per-pin history and compare, vectorised over `NUM_PINS`. It is instantiated only under `GPIO_DEBOUNCE_EN`.

## Test plan
- **Reset:** assert `reset` with pads = `0xFFFF_FFFF` -> `o_pad_oen` = `0xFFFF_FFFF`, `o_pad_i` = 0, `o_irq` = 0; after release, no pending bits with enables = 0.
- **Output path:** `i_gpio_dir` = `0x0000_00FF`, `i_gpio_out` = `0x0000_00A5` -> one cycle later `o_pad_oen` = `0xFFFF_FF00`, `o_pad_i` = `0x0000_00A5`.
- **Rising edge:** `i_db_limit` = 0, `i_rise_en[3]` = 1, pad 3 goes 0->1 -> `o_gpio_in[3]` rises `SYNC_STAGES+3` edges later, `o_irq_pending[3]` and `o_irq` one cycle after that; `i_irq_clr[3]` pulse -> pending clears next cycle.
- **Glitch rejection:** `i_db_limit` = 9, pad 5 high for 15 cycles -> `o_gpio_in[5]` stays 0; high for 40 cycles -> rises within `SYNC_STAGES+30` cycles.
- **Clear vs set:** `i_irq_clr[7]` pulse in the same cycle as a new falling edge on pin 7 with `i_fall_en[7]` = 1 -> pending bit 7 remains 1.
- **Macro off:** without `GPIO_DEBOUNCE_EN`, pad 0 high for a single cycle -> `o_gpio_in[0]` pulses for one cycle after `SYNC_STAGES` edges; with `i_rise_en[0]` set, pending bit 0 is set.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO constants, edge classification type and helper.
package gpio_pkg;

   localparam int GPIO_NUM_PINS    = 32;
   localparam int GPIO_SYNC_STAGES = 2;
   localparam int GPIO_DB_CNT_W    = 16;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } gpio_edge_t;

   function automatic gpio_edge_t edge_kind(input logic cur, input logic prev);
      if (cur && !prev) begin
         return EDGE_RISE;
      end else if (!cur && prev) begin
         return EDGE_FALL;
      end
      return EDGE_NONE;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Shared tick prescaler plus per-pin 3-sample agreement filter.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int NUM_PINS = GPIO_NUM_PINS,
   parameter int DB_CNT_W = GPIO_DB_CNT_W
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PINS-1:0] i_sample,
   input  logic [DB_CNT_W-1:0] i_db_limit,
   output logic [NUM_PINS-1:0] o_cond
);

   logic [DB_CNT_W-1:0] r_count;
   logic [NUM_PINS-1:0] r_hist0;
   logic [NUM_PINS-1:0] r_hist1;
   logic [NUM_PINS-1:0] r_cond;
   logic                w_tick;
   logic [NUM_PINS-1:0] w_stable;

   // >= rather than == so a limit lowered below the count still ticks promptly.
   assign w_tick   = (r_count >= i_db_limit);
   assign w_stable = ~(i_sample ^ r_hist0) & ~(i_sample ^ r_hist1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_hist0 <= '0;
         r_hist1 <= '0;
         r_cond  <= '0;
      end else begin
         r_count <= w_tick ? '0 : r_count + DB_CNT_W'(1);
         if (w_tick) begin
            r_hist0 <= i_sample;
            r_hist1 <= r_hist0;
            r_cond  <= (r_cond & ~w_stable) | (i_sample & w_stable);
         end
      end
   end

   assign o_cond = r_cond;

endmodule

// File: rtl/gpio_pad_if.sv
// Pad-side conditioning for GPIO: registered output path, synchronised input path,
// sticky edge interrupts. Debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_pad_if
   import gpio_pkg::*;
#(
   parameter int NUM_PINS    = GPIO_NUM_PINS,
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DB_CNT_W    = GPIO_DB_CNT_W
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PINS-1:0] i_pad_c,
   output logic [NUM_PINS-1:0] o_pad_i,
   output logic [NUM_PINS-1:0] o_pad_oen,
   input  logic [NUM_PINS-1:0] i_gpio_out,
   input  logic [NUM_PINS-1:0] i_gpio_dir,
   output logic [NUM_PINS-1:0] o_gpio_in,
   input  logic [NUM_PINS-1:0] i_rise_en,
   input  logic [NUM_PINS-1:0] i_fall_en,
   input  logic [NUM_PINS-1:0] i_irq_clr,
   output logic [NUM_PINS-1:0] o_irq_pending,
   output logic                o_irq,
   input  logic [DB_CNT_W-1:0] i_db_limit
);

   logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
   logic [NUM_PINS-1:0] r_pad_i;
   logic [NUM_PINS-1:0] r_pad_oen;
   logic [NUM_PINS-1:0] r_prev;
   logic [NUM_PINS-1:0] r_pending;
   logic [NUM_PINS-1:0] w_sync_out;
   logic [NUM_PINS-1:0] w_cond;
   logic [NUM_PINS-1:0] w_rise;
   logic [NUM_PINS-1:0] w_fall;

   // Pads come out of reset as inputs so nothing is driven before software configures them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pad_i   <= '0;
         r_pad_oen <= '1;
      end else begin
         r_pad_i   <= i_gpio_out;
         r_pad_oen <= ~i_gpio_dir;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= i_pad_c;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   gpio_debounce #(
      .NUM_PINS (NUM_PINS),
      .DB_CNT_W (DB_CNT_W)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .i_sample   (w_sync_out),
      .i_db_limit (i_db_limit),
      .o_cond     (w_cond)
   );
`else
   logic w_db_limit_unused;

   assign w_db_limit_unused = ^i_db_limit;
   assign w_cond            = w_sync_out;
`endif

   always_comb begin
      w_rise = '0;
      w_fall = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         w_rise[i] = (edge_kind(w_cond[i], r_prev[i]) == EDGE_RISE) && i_rise_en[i];
         w_fall[i] = (edge_kind(w_cond[i], r_prev[i]) == EDGE_FALL) && i_fall_en[i];
      end
   end

   // A new edge in the same cycle as its clear pulse wins, so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev    <= '0;
         r_pending <= '0;
      end else begin
         r_prev    <= w_cond;
         r_pending <= (r_pending & ~i_irq_clr) | w_rise | w_fall;
      end
   end

   assign o_pad_i       = r_pad_i;
   assign o_pad_oen     = r_pad_oen;
   assign o_gpio_in     = w_cond;
   assign o_irq_pending = r_pending;
   assign o_irq         = |r_pending;

endmodule

// File: tb/tb_gpio_pad_if.sv
// Self-checking bench for gpio_pad_if: directed scenarios plus a randomized run
// against a delay-line / sample-agreement reference model.
module tb_gpio_pad_if;
   import gpio_pkg::*;

   localparam int W    = GPIO_NUM_PINS;
   localparam int SYNC = GPIO_SYNC_STAGES;
   localparam int DBW  = GPIO_DB_CNT_W;
`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = SYNC + 3;
`else
   localparam int LAT = SYNC;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   i_pad_c, o_pad_i, o_pad_oen, i_gpio_out, i_gpio_dir, o_gpio_in;
   logic [W-1:0]   i_rise_en, i_fall_en, i_irq_clr, o_irq_pending;
   logic           o_irq;
   logic [DBW-1:0] i_db_limit;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [W-1:0] pad_q[$];
   logic [W-1:0] s_seen[$];
   logic [W-1:0] m_s, m_cond, m_in, m_in_last, m_pend, m_pad_i, m_oen;

   always #5 clk = ~clk;

   gpio_pad_if dut (
      .clk           (clk),
      .reset         (reset),
      .i_pad_c       (i_pad_c),
      .o_pad_i       (o_pad_i),
      .o_pad_oen     (o_pad_oen),
      .i_gpio_out    (i_gpio_out),
      .i_gpio_dir    (i_gpio_dir),
      .o_gpio_in     (o_gpio_in),
      .i_rise_en     (i_rise_en),
      .i_fall_en     (i_fall_en),
      .i_irq_clr     (i_irq_clr),
      .o_irq_pending (o_irq_pending),
      .o_irq         (o_irq),
      .i_db_limit    (i_db_limit)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      i_pad_c    = '0;
      i_gpio_out = '0;
      i_gpio_dir = '0;
      i_rise_en  = '0;
      i_fall_en  = '0;
      i_irq_clr  = '0;
   endtask

   task automatic model_reset();
      pad_q.delete();
      s_seen.delete();
      for (int k = 0; k < SYNC; k++) pad_q.push_back('0);
      s_seen.push_back('0);
      s_seen.push_back('0);
      m_s       = '0;
      m_cond    = '0;
      m_in      = '0;
      m_in_last = '0;
      m_pend    = '0;
      m_pad_i   = '0;
      m_oen     = '1;
   endtask

   task automatic do_reset(input logic [W-1:0] pads);
      drive_idle();
      i_pad_c = pads;
      reset   = 1'b1;
      step();
      step();
      reset = 1'b0;
      model_reset();
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [W-1:0] nxt;
      m_pend = (m_pend & ~i_irq_clr) | (i_rise_en & m_in & ~m_in_last)
             | (i_fall_en & ~m_in & m_in_last);
`ifdef GPIO_DEBOUNCE_EN
      s_seen.push_back(m_s);
      if (s_seen.size() > 3) void'(s_seen.pop_front());
      for (int i = 0; i < W; i++)
         if (s_seen[0][i] == s_seen[1][i] && s_seen[1][i] == s_seen[2][i])
            m_cond[i] = s_seen[2][i];
      nxt = m_cond;
`endif
      pad_q.push_back(i_pad_c);
      void'(pad_q.pop_front());
      m_s = pad_q[0];
`ifndef GPIO_DEBOUNCE_EN
      nxt = m_s;
`endif
      m_in_last = m_in;
      m_in      = nxt;
      m_pad_i   = i_gpio_out;
      m_oen     = ~i_gpio_dir;
   endtask

   task automatic test_reset();
      drive_idle();
      i_gpio_dir = '1;
      i_gpio_out = '1;
      step();
      n_tests++;
      if (o_pad_oen !== '0) begin n_fail++; $display("FAIL pre_reset_oen: got %h want %h", o_pad_oen, 32'h0); end
      i_pad_c = '1;
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (o_pad_oen !== '1) begin n_fail++; $display("FAIL async_reset_oen: got %h want %h", o_pad_oen, 32'hFFFF_FFFF); end
      n_tests++;
      if (o_pad_i !== '0) begin n_fail++; $display("FAIL async_reset_pad_i: got %h want %h", o_pad_i, 32'h0); end
      step();
      n_tests++;
      if (o_irq !== 1'b0 || o_irq_pending !== '0 || o_gpio_in !== '0) begin
         n_fail++; $display("FAIL reset_state: irq %b pend %h in %h want 0 0 0", o_irq, o_irq_pending, o_gpio_in);
      end
      i_gpio_dir = '0;
      i_gpio_out = '0;
      step();
      reset = 1'b0;
      repeat (LAT + 4) step();
      n_tests++;
      if (o_gpio_in !== '1) begin n_fail++; $display("FAIL post_reset_in: got %h want %h", o_gpio_in, 32'hFFFF_FFFF); end
      n_tests++;
      if (o_irq_pending !== '0 || o_irq !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_pending: got %h/%b want 0/0", o_irq_pending, o_irq);
      end
   endtask

   task automatic test_output_path();
      logic [W-1:0] out_v, dir_v;
      do_reset('0);
      i_gpio_dir = 32'h0000_00FF;
      i_gpio_out = 32'h0000_00A5;
      step();
      n_tests++;
      if (o_pad_oen !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL out_oen: got %h want %h", o_pad_oen, 32'hFFFF_FF00); end
      n_tests++;
      if (o_pad_i !== 32'h0000_00A5) begin n_fail++; $display("FAIL out_pad_i: got %h want %h", o_pad_i, 32'h0000_00A5); end
      i_gpio_out = 32'h1234_5678;
      #1;
      n_tests++;
      if (o_pad_i !== 32'h0000_00A5) begin n_fail++; $display("FAIL out_registered: got %h want %h", o_pad_i, 32'h0000_00A5); end
      for (int k = 0; k < 16; k++) begin
         out_v = $urandom;
         dir_v = $urandom;
         i_gpio_out = out_v;
         i_gpio_dir = dir_v;
         step();
         n_tests++;
         if (o_pad_i !== out_v || o_pad_oen !== ~dir_v) begin
            n_fail++; $display("FAIL out_random: got %h/%h want %h/%h", o_pad_i, o_pad_oen, out_v, ~dir_v);
         end
      end
   endtask

   task automatic test_rising_edge();
      do_reset('0);
      i_rise_en = 32'h8;
      i_pad_c   = 32'h8;
      repeat (LAT - 1) step();
      n_tests++;
      if (o_gpio_in[3] !== 1'b0) begin n_fail++; $display("FAIL rise_early: got %b want 0", o_gpio_in[3]); end
      step();
      n_tests++;
      if (o_gpio_in[3] !== 1'b1 || o_irq_pending !== '0) begin
         n_fail++; $display("FAIL rise_in: got in %b pend %h want 1 0", o_gpio_in[3], o_irq_pending);
      end
      step();
      n_tests++;
      if (o_irq_pending !== 32'h8 || o_irq !== 1'b1) begin
         n_fail++; $display("FAIL rise_pending: got %h/%b want %h/1", o_irq_pending, o_irq, 32'h8);
      end
      i_irq_clr = 32'h8;
      step();
      i_irq_clr = '0;
      n_tests++;
      if (o_irq_pending !== '0 || o_irq !== 1'b0) begin
         n_fail++; $display("FAIL rise_clear: got %h/%b want 0/0", o_irq_pending, o_irq);
      end
   endtask

   task automatic test_clear_vs_set();
      do_reset('0);
      i_rise_en = 32'h80;
      i_fall_en = 32'h80;
      i_pad_c   = 32'h80;
      repeat (LAT + 1) step();
      n_tests++;
      if (o_irq_pending !== 32'h80) begin n_fail++; $display("FAIL cvs_setup: got %h want %h", o_irq_pending, 32'h80); end
      i_pad_c = '0;
      repeat (LAT) step();
      n_tests++;
      if (o_gpio_in[7] !== 1'b0) begin n_fail++; $display("FAIL cvs_fall_in: got %b want 0", o_gpio_in[7]); end
      i_irq_clr = 32'h80;
      step();
      i_irq_clr = '0;
      n_tests++;
      if (o_irq_pending[7] !== 1'b1) begin n_fail++; $display("FAIL cvs_set_wins: got %b want 1", o_irq_pending[7]); end
      i_irq_clr = 32'h80;
      step();
      i_irq_clr = '0;
      n_tests++;
      if (o_irq_pending !== '0) begin n_fail++; $display("FAIL cvs_clear: got %h want 0", o_irq_pending); end
   endtask

`ifndef GPIO_DEBOUNCE_EN
   task automatic test_single_pulse();
      do_reset('0);
      i_rise_en = 32'h1;
      i_pad_c   = 32'h1;
      step();
      i_pad_c = '0;
      n_tests++;
      if (o_gpio_in[0] !== 1'b0) begin n_fail++; $display("FAIL pulse_early: got %b want 0", o_gpio_in[0]); end
      step();
      n_tests++;
      if (o_gpio_in[0] !== 1'b1) begin n_fail++; $display("FAIL pulse_high: got %b want 1", o_gpio_in[0]); end
      step();
      n_tests++;
      if (o_gpio_in[0] !== 1'b0 || o_irq_pending !== 32'h1 || o_irq !== 1'b1) begin
         n_fail++; $display("FAIL pulse_end: got in %b pend %h irq %b want 0 1 1", o_gpio_in[0], o_irq_pending, o_irq);
      end
   endtask
`else
   task automatic test_glitch();
      bit seen;
      int waited;
      i_db_limit = 16'd9;
      do_reset('0);
      seen    = 1'b0;
      i_pad_c = 32'h20;
      repeat (15) begin step(); if (o_gpio_in[5]) seen = 1'b1; end
      i_pad_c = '0;
      repeat (40) begin step(); if (o_gpio_in[5]) seen = 1'b1; end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL glitch_rejected: got 1 want 0"); end
      i_pad_c = 32'h20;
      waited  = 0;
      while (o_gpio_in[5] !== 1'b1 && waited < SYNC + 30) begin step(); waited++; end
      n_tests++;
      if (o_gpio_in[5] !== 1'b1) begin n_fail++; $display("FAIL glitch_accept: got %b after %0d want 1", o_gpio_in[5], waited); end
      i_db_limit = '0;
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] flip;
      do_reset('0);
      for (int c = 0; c < 400; c++) begin
         flip = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
         i_pad_c ^= flip;
         if ($urandom_range(0, 15) == 0) begin
            i_rise_en = $urandom;
            i_fall_en = $urandom;
         end
         i_irq_clr  = $urandom & $urandom & $urandom;
         i_gpio_out = $urandom;
         i_gpio_dir = $urandom;
         model_edge();
         step();
         n_tests++;
         if (o_pad_i !== m_pad_i || o_pad_oen !== m_oen) begin
            n_fail++; $display("FAIL rnd_out c%0d: got %h/%h want %h/%h", c, o_pad_i, o_pad_oen, m_pad_i, m_oen);
         end
         n_tests++;
         if (o_gpio_in !== m_in) begin n_fail++; $display("FAIL rnd_in c%0d: got %h want %h", c, o_gpio_in, m_in); end
         n_tests++;
         if (o_irq_pending !== m_pend || o_irq !== (|m_pend)) begin
            n_fail++; $display("FAIL rnd_pend c%0d: got %h/%b want %h/%b", c, o_irq_pending, o_irq, m_pend, |m_pend);
         end
      end
      i_irq_clr = '0;
   endtask

   initial begin
      reset      = 1'b1;
      i_db_limit = '0;
      drive_idle();
      step();
      reset = 1'b0;
      test_reset();
      test_output_path();
      test_rising_edge();
      test_clear_vs_set();
`ifndef GPIO_DEBOUNCE_EN
      test_single_pulse();
`else
      test_glitch();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
